uart_mmio: RTL and testbench



---
 rtl/uart_mmio_if.sv | 25 ++
 rtl/uart_mmio.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_if.sv
// Bus-side port bundle for the UART MMIO peripheral: bridged address, write data,
// byte enables, load strobe and combinational read data.
interface uart_mmio_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic        load;
    logic [31:0] rdata;

    modport master (
        output addr,
        output byteen,
        output wdata,
        output load,
        input  rdata
    );

    modport slave (
        input  addr,
        input  byteen,
        input  wdata,
        input  load,
        output rdata
    );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: DATA/STATUS/DIV/CTRL registers, TX shifter, RX sampler
// behind a 2-flop synchronizer, and a level interrupt on a pending received byte.
module uart_mmio #(
    parameter int unsigned DIV_DEFAULT = 434,
    parameter int unsigned DIV_MIN     = 4
) (
    input  logic        clk,
    input  logic        reset,
    uart_mmio_if.slave  bus,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);

    localparam logic [15:0] DivDefault = 16'(DIV_DEFAULT);
    localparam logic [15:0] DivMin     = 16'(DIV_MIN);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Register file state
    logic [15:0] div_q, div_d;
    logic        ctrl_q, ctrl_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  rx_data_q, rx_data_d;

    // TX state
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;

    // RX state
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done, rx_stop_ok;

    // Bus decode
    logic [1:0]  reg_sel;
    logic        wr_en, tx_start, rd_clear;
    logic [15:0] eff_div, rx_half;
    logic        unused_bits;

    assign reg_sel  = bus.addr[3:2];
    assign wr_en    = |bus.byteen;
    assign tx_start = bus.byteen[0] && (reg_sel == 2'd0) && (tx_state_q == TxIdle);
    assign rd_clear = bus.load && (reg_sel == 2'd0);
    // Divisor is clamped at use, so DIV reads back exactly what was written
    assign eff_div  = (div_q < DivMin) ? DivMin : div_q;
    assign rx_half  = {1'b0, rx_div_q[15:1]};
    assign irq      = rx_valid_q & ctrl_q;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

    // Combinational read mux
    always_comb begin
        bus.rdata = 32'h0;
        unique case (reg_sel)
            2'd0: bus.rdata = {24'h0, rx_data_q};
            2'd1: bus.rdata = {28'h0, frame_err_q, overrun_q, (tx_state_q != TxIdle), rx_valid_q};
            2'd2: bus.rdata = {16'h0, div_q};
            2'd3: bus.rdata = {31'h0, ctrl_q};
        endcase
    end

    // TX next-state: one start bit, eight data bits LSB first, one stop bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd        = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_start) begin
                    tx_state_d = TxStart;
                    tx_cnt_d   = 16'h0;
                    tx_div_d   = eff_div;
                    tx_shift_d = bus.wdata[7:0];
                end
            end
            TxStart: begin
                txd = 1'b0;
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = 16'h0;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxData: begin
                txd = tx_shift_q[0];
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d   = 16'h0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
        endcase
    end

    // RX next-state: start bit checked at half a bit time, then full-bit spacing
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_stop_ok = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = 16'h0;
                    rx_div_d   = eff_div;
                end
            end
            RxStart: begin
                if (rx_cnt_q == rx_half - 16'd1) begin
                    rx_cnt_d = 16'h0;
                    rx_bit_d = 3'd0;
                    // A high sample here means the falling edge was a glitch
                    rx_state_d = rx_sync2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d   = 16'h0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_state_d = RxIdle;
                    rx_done    = 1'b1;
                    rx_stop_ok = rx_sync2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
        endcase
    end

    // Register writes, read side effects and RX completion; sets win over clears
    always_comb begin
        div_d       = div_q;
        ctrl_d      = ctrl_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_data_d   = rx_data_q;
        if (rd_clear) begin
            rx_valid_d = 1'b0;
        end
        if (wr_en) begin
            if (reg_sel == 2'd1 && bus.byteen[0]) begin
                overrun_d   = overrun_q & ~bus.wdata[2];
                frame_err_d = frame_err_q & ~bus.wdata[3];
            end
            if (reg_sel == 2'd2) begin
                if (bus.byteen[0]) div_d[7:0]  = bus.wdata[7:0];
                if (bus.byteen[1]) div_d[15:8] = bus.wdata[15:8];
            end
            if (reg_sel == 2'd3 && bus.byteen[0]) begin
                ctrl_d = bus.wdata[0];
            end
        end
        if (rx_done) begin
            if (rx_stop_ok) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                // A byte consumed in this very cycle is not an overrun
                if (rx_valid_q && !rd_clear) overrun_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // Register file state update
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= DivDefault;
            ctrl_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= 8'h0;
        end else begin
            div_q       <= div_d;
            ctrl_q      <= ctrl_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
        end
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= 16'h0;
            tx_div_q   <= DivDefault;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // RX synchronizer, edge history and state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= 16'h0;
            rx_div_q   <= DivDefault;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h0;
        end else begin
            rx_sync1_q <= rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized self-checking bench for uart_mmio against a frame-level reference model.
module tb_uart_mmio;

    localparam int unsigned DivDef = 8;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic txd;
    logic irq;

    uart_mmio_if bus ();

    uart_mmio #(
        .DIV_DEFAULT(DivDef),
        .DIV_MIN    (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .rxd  (rxd),
        .txd  (txd),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the architectural register state
    logic       m_valid, m_ovr, m_ferr, m_ctrl;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_ctrl  = 1'b0;
        m_data  = 8'h0;
    endtask

    // A completed frame as seen from the register map
    task automatic model_rx(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.addr   = a;
        bus.wdata  = d;
        bus.byteen = be;
        @(negedge clk);
        bus.byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.load = 1'b0;
        #1 d = bus.rdata;
    endtask

    task automatic rd_load(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.load = 1'b1;
        #1 d = bus.rdata;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        rd(32'h4, v);
        check({tag, "_status"}, v, {28'h0, m_ferr, m_ovr, 1'b0, m_valid});
        rd(32'h0, v);
        check({tag, "_data"}, v, {24'h0, m_data});
        check({tag, "_irq"}, 32'(irq), 32'(m_valid & m_ctrl));
    endtask

    // Drive one 8N1 frame on rxd; returns while the stop bit is still on the line
    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = frame[i];
            repeat (d - 1) @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input int d);
        send_rx(b, stop, d);
        if (!stop) begin
            @(negedge clk);
            rxd = 1'b1;
            repeat (d) @(negedge clk);
        end
        model_rx(b, stop);
    endtask

    // Send a byte and follow txd cycle by cycle against the ideal waveform
    task automatic tx_check(input logic [7:0] b, input int d, input bit inject);
        logic [9:0] frame;
        int lows;
        frame = {1'b1, b, 1'b0};
        wr(32'h0, {24'h0, b}, 4'h1);
        for (int c = 0; c < 10 * d; c++) begin
            if (c > 0) @(negedge clk);
            bus.addr   = 32'h4;
            bus.byteen = 4'h0;
            if (inject && c == 2 * d) begin
                bus.addr   = 32'h0;
                bus.wdata  = {24'h0, ~b};
                bus.byteen = 4'h1;
            end
            #1;
            check("txd", 32'(txd), 32'(frame[c / d]));
            if (c == 0 || c == 10 * d - 1) check("tx_busy", 32'(bus.rdata[1]), 32'h1);
        end
        @(negedge clk);
        bus.addr = 32'h4;
        #1;
        check("tx_idle_busy", 32'(bus.rdata[1]), 32'h0);
        check("tx_idle_txd", 32'(txd), 32'h1);
        if (inject) begin
            lows = 0;
            repeat (3 * d) begin
                @(negedge clk);
                if (!txd) lows++;
            end
            check("no_second_frame", 32'(lows), 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] w;
        logic [7:0]  b;
        logic        stop;
        int          d;

        bus.addr   = 32'h0;
        bus.wdata  = 32'h0;
        bus.byteen = 4'h0;
        bus.load   = 1'b0;
        rxd        = 1'b1;
        reset      = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'h1);
        reset = 1'b0;

        // Reset state
        check("reset_irq", 32'(irq), 32'h0);
        check_regs("reset");
        rd(32'h8, v);
        check("reset_div", v, DivDef);
        rd(32'hC, v);
        check("reset_ctrl", v, 32'h0);

        // Known TX frame, with a write while busy that must be dropped
        tx_check(8'hA5, 8, 1'b1);

        // DIV byte lanes and zero-byteen writes
        wr(32'h8, 32'h0000_ABCD, 4'h2);
        rd(32'h8, v);
        check("div_hi_lane", v, 32'hAB08);
        wr(32'h8, 32'h0000_1234, 4'h0);
        rd(32'h8, v);
        check("div_no_be", v, 32'hAB08);

        // Random TX bytes at random divisors
        for (int i = 0; i < 3; i++) begin
            d = $urandom_range(4, 10);
            wr(32'h8, 32'(d), 4'h3);
            tx_check(8'($urandom), d, 1'b0);
        end
        wr(32'h8, 32'(DivDef), 4'h3);

        // RX with interrupt enabled, then read-clear
        wr(32'hC, 32'h1, 4'h1);
        m_ctrl = 1'b1;
        rx_frame(8'h3C, 1'b1, 8);
        check_regs("rx3c");
        rd_load(32'h0, v);
        check("rx3c_load_data", v, 32'h3C);
        m_valid = 1'b0;
        check("rx3c_irq_clr", 32'(irq), 32'h0);
        check_regs("rx3c_clr");

        // Overrun and its W1C clear
        rx_frame(8'h11, 1'b1, 8);
        rx_frame(8'h22, 1'b1, 8);
        check_regs("ovr");
        wr(32'h4, 32'h4, 4'h1);
        m_ovr = 1'b0;
        check_regs("ovr_w1c");

        // Read-clear coincident with completion: byte held, no overrun
        fork
            send_rx(8'h5A, 1'b1, 8);
            begin
                repeat (79) @(negedge clk);
                bus.addr = 32'h0;
                bus.load = 1'b1;
                @(negedge clk);
                bus.load = 1'b0;
            end
        join
        m_data  = 8'h5A;
        m_valid = 1'b1;
        check_regs("same_cycle");
        rd_load(32'h0, v);
        m_valid = 1'b0;

        // Framing error and glitch rejection
        rx_frame(8'h77, 1'b0, 8);
        check_regs("ferr");
        wr(32'h4, 32'h8, 4'h1);
        m_ferr = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check_regs("glitch");
        rx_frame(8'hC3, 1'b1, 8);
        check_regs("after_glitch");

        // Random RX traffic with random clears and control changes
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rx_frame(b, stop, 8);
            check_regs("rand_rx");
            if ($urandom_range(0, 1) == 1) begin
                rd_load(32'h0, v);
                check("rand_load_data", v, {24'h0, m_data});
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                w = 32'($urandom_range(0, 15));
                wr(32'h4, w, 4'h1);
                m_ovr  = m_ovr & ~w[2];
                m_ferr = m_ferr & ~w[3];
            end
            m_ctrl = 1'($urandom_range(0, 1));
            wr(32'hC, {31'h0, m_ctrl}, 4'h1);
        end
        check_regs("rand_end");

        // Clamp of small divisors
        wr(32'h8, 32'h2, 4'h3);
        rd(32'h8, v);
        check("div_clamp_rd", v, 32'h2);
        tx_check(8'($urandom), 4, 1'b0);

        // Reset in the middle of a TX frame
        wr(32'h0, 32'h0, 4'h1);
        repeat (5) @(negedge clk);
        check("mid_tx_low", 32'(txd), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_tx_reset_txd", 32'(txd), 32'h1);
        reset = 1'b0;
        model_reset();
        rd(32'h8, v);
        check("mid_tx_reset_div", v, DivDef);
        check_regs("mid_tx_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
